// File: rtl/player_2_packet_rx.sv
// Frames and validates 6-byte player-2 state packets from the UART byte stream,
// committing accepted packets to registered outputs with a one-cycle valid pulse.
module player_2_packet_rx #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         BYTE_TIMEOUT = 65_000,
    parameter int         LINK_TIMEOUT = 6_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] player_2_x,
    output logic [11:0] player_2_y,
    output logic        player_2_flip_h,
    output logic [1:0]  player_2_class,
    output logic [3:0]  player_2_hp,
    output logic        player_2_data_valid,
    output logic        link_alive,
    output logic [7:0]  pkt_err_cnt
);

    localparam int GW = $clog2(BYTE_TIMEOUT + 1);
    localparam int LW = $clog2(LINK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, B1, B2, B3, B4, CHK} state_t;

    state_t         state, state_nxt;
    logic [7:0]     sh_b1, sh_b2, sh_b3, sh_b4;
    logic [GW-1:0]  gap_cnt;
    logic [LW-1:0]  link_cnt;
    logic           accept, reject, timeout;
    logic [7:0]     csum;
    logic [1:0]     sh_class;

    assign csum     = sh_b1 ^ sh_b2 ^ sh_b3 ^ sh_b4;
    assign sh_class = sh_b4[6:5];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_nxt = B1;
            B1:   if (rx_valid) state_nxt = B2;
            B2:   if (rx_valid) state_nxt = B3;
            B3:   if (rx_valid) state_nxt = B4;
            B4:   if (rx_valid) state_nxt = CHK;
            CHK: begin
                if (rx_valid) begin
                    state_nxt = IDLE;
                    if (rx_data == csum && sh_class != 2'd3) accept = 1'b1;
                    else                                     reject = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A byte arriving on the last allowed cycle keeps the packet alive
        if (state != IDLE && !rx_valid && gap_cnt == GW'(BYTE_TIMEOUT - 1)) begin
            state_nxt = IDLE;
            timeout   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_b1 <= 8'd0;
            sh_b2 <= 8'd0;
            sh_b3 <= 8'd0;
            sh_b4 <= 8'd0;
        end else if (rx_valid) begin
            case (state)
                B1:      sh_b1 <= rx_data;
                B2:      sh_b2 <= rx_data;
                B3:      sh_b3 <= rx_data;
                B4:      sh_b4 <= rx_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state == IDLE || rx_valid || timeout) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            player_2_x          <= 12'd0;
            player_2_y          <= 12'd0;
            player_2_flip_h     <= 1'b0;
            player_2_class      <= 2'd0;
            player_2_hp         <= 4'd0;
            player_2_data_valid <= 1'b0;
        end else begin
            player_2_data_valid <= accept;
            if (accept) begin
                player_2_x      <= {sh_b1, sh_b2[7:4]};
                player_2_y      <= {sh_b2[3:0], sh_b3};
                player_2_flip_h <= sh_b4[7];
                player_2_class  <= sh_b4[6:5];
                player_2_hp     <= sh_b4[4:1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_err_cnt <= 8'd0;
        end else if ((reject || timeout) && pkt_err_cnt != 8'hFF) begin
            pkt_err_cnt <= pkt_err_cnt + 8'd1;
        end
    end

    // link_alive falls on the same edge the counter saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            link_cnt   <= '0;
            link_alive <= 1'b0;
        end else if (accept) begin
            link_cnt   <= '0;
            link_alive <= 1'b1;
        end else begin
            if (link_cnt != LW'(LINK_TIMEOUT)) link_cnt <= link_cnt + LW'(1);
            if (link_cnt == LW'(LINK_TIMEOUT - 1)) link_alive <= 1'b0;
        end
    end

endmodule

// File: tb/tb_player_2_packet_rx.sv
// Randomized and directed bench for player_2_packet_rx against a byte-queue
// reference model of the packet rules, compared on every clock cycle.
module tb_player_2_packet_rx;

    localparam int BT = 50;
    localparam int LT = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] player_2_x, player_2_y;
    logic        player_2_flip_h;
    logic [1:0]  player_2_class;
    logic [3:0]  player_2_hp;
    logic        player_2_data_valid;
    logic        link_alive;
    logic [7:0]  pkt_err_cnt;

    player_2_packet_rx #(
        .SYNC_BYTE    (8'hA5),
        .BYTE_TIMEOUT (BT),
        .LINK_TIMEOUT (LT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .player_2_x          (player_2_x),
        .player_2_y          (player_2_y),
        .player_2_flip_h     (player_2_flip_h),
        .player_2_class      (player_2_class),
        .player_2_hp         (player_2_hp),
        .player_2_data_valid (player_2_data_valid),
        .link_alive          (link_alive),
        .pkt_err_cnt         (pkt_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model state: collected bytes after the sync, idle gap, expected outputs
    logic        m_in_pkt;
    logic [7:0]  m_q[$];
    int          m_idle;
    int          m_since;
    logic        m_seen;
    logic [11:0] ex, ey;
    logic        ef, edv, ealive;
    logic [1:0]  ec;
    logic [3:0]  eh;
    logic [7:0]  eerr;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_in_pkt = 1'b0;
        m_q.delete();
        m_idle  = 0;
        m_since = 0;
        m_seen  = 1'b0;
        ex = '0; ey = '0; ef = 1'b0; ec = '0; eh = '0;
        edv = 1'b0; ealive = 1'b0; eerr = '0;
    endtask

    task automatic modelStep(input logic v, input logic [7:0] d);
        logic       acc;
        logic [7:0] b4, xr;
        acc = 1'b0;
        if (!m_in_pkt) begin
            if (v && d == 8'hA5) begin
                m_in_pkt = 1'b1;
                m_q.delete();
                m_idle = 0;
            end
        end else if (v) begin
            m_idle = 0;
            if (m_q.size() < 4) begin
                m_q.push_back(d);
            end else begin
                b4 = m_q[3];
                xr = m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3];
                if (d == xr && b4[6:5] != 2'd3) begin
                    acc = 1'b1;
                    ex  = {m_q[0], m_q[1][7:4]};
                    ey  = {m_q[1][3:0], m_q[2]};
                    ef  = b4[7];
                    ec  = b4[6:5];
                    eh  = b4[4:1];
                end else if (eerr != 8'hFF) begin
                    eerr = eerr + 8'd1;
                end
                m_in_pkt = 1'b0;
            end
        end else begin
            m_idle++;
            if (m_idle == BT) begin
                m_in_pkt = 1'b0;
                if (eerr != 8'hFF) eerr = eerr + 8'd1;
            end
        end
        edv = acc;
        if (acc) begin
            m_since = 0;
            m_seen  = 1'b1;
        end else if (m_since < LT) begin
            m_since++;
        end
        ealive = m_seen && (m_since < LT);
    endtask

    task automatic compareAll();
        checkOutput("x", 32'(player_2_x), 32'(ex));
        checkOutput("y", 32'(player_2_y), 32'(ey));
        checkOutput("flip_h", 32'(player_2_flip_h), 32'(ef));
        checkOutput("class", 32'(player_2_class), 32'(ec));
        checkOutput("hp", 32'(player_2_hp), 32'(eh));
        checkOutput("data_valid", 32'(player_2_data_valid), 32'(edv));
        checkOutput("link_alive", 32'(link_alive), 32'(ealive));
        checkOutput("pkt_err_cnt", 32'(pkt_err_cnt), 32'(eerr));
        if (player_2_data_valid === 1'b1) pulses++;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        modelStep(v, d);
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        modelReset();
        @(posedge clk);
        #1;
        compareAll();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        repeat (gap) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic sendPacket(input logic [11:0] x, input logic [11:0] y, input logic f,
                              input logic [1:0] c, input logic [3:0] h, input logic rsvd,
                              input logic corrupt, input int gap);
        logic [7:0] b1, b2, b3, b4, b5;
        b1 = x[11:4];
        b2 = {x[3:0], y[11:8]};
        b3 = y[7:0];
        b4 = {f, c, h, rsvd};
        b5 = b1 ^ b2 ^ b3 ^ b4;
        if (corrupt) b5 = b5 ^ 8'h01;
        sendByte(8'hA5, gap);
        sendByte(b1, gap);
        sendByte(b2, gap);
        sendByte(b3, gap);
        sendByte(b4, gap);
        sendByte(b5, gap);
    endtask

    initial begin
        int kind, p0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        modelReset();
        doReset();

        // Reference packet x=500 y=300 flip=1 class=2 hp=5, one byte every 10 cycles
        sendPacket(12'd500, 12'd300, 1'b1, 2'd2, 4'd5, 1'b0, 1'b0, 9);
        checkOutput("ref_x", 32'(player_2_x), 32'h1F4);
        checkOutput("ref_y", 32'(player_2_y), 32'h12C);
        idle(3);

        sendPacket(12'd500, 12'd300, 1'b1, 2'd2, 4'd5, 1'b0, 1'b1, 2);
        checkOutput("bad_csum_err", 32'(pkt_err_cnt), 32'd1);

        sendByte(8'h00, 1);
        sendByte(8'hFF, 1);
        sendByte(8'h3C, 1);
        sendPacket(12'h123, 12'h456, 1'b0, 2'd1, 4'd9, 1'b1, 1'b0, 1);

        // Partial packet dropped after exactly BT idle cycles, then a packet at once
        sendByte(8'hA5, 0);
        sendByte(8'h1F, 0);
        sendByte(8'h41, 0);
        idle(BT);
        sendPacket(12'hABC, 12'h0DE, 1'b1, 2'd0, 4'd15, 1'b0, 1'b0, 0);

        // BT-1 idle cycles inside a packet is still legal
        sendPacket(12'hFFF, 12'hFFF, 1'b1, 2'd1, 4'd3, 1'b1, 1'b0, BT - 1);

        sendPacket(12'd10, 12'd20, 1'b1, 2'd3, 4'd0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 3) begin
                sendByte(8'($urandom_range(0, 164)), $urandom_range(0, 4));
                sendByte(8'($urandom_range(166, 255)), $urandom_range(0, 4));
            end
            if (kind == 2) begin
                sendByte(8'hA5, $urandom_range(0, 3));
                for (int k = 0; k < int'($urandom_range(0, 4)); k++)
                    sendByte(8'($urandom), $urandom_range(0, 3));
                idle(BT + $urandom_range(0, 3));
            end else begin
                sendPacket(12'($urandom), 12'($urandom), 1'($urandom),
                           (kind == 1) ? 2'd3 : 2'($urandom_range(0, 2)), 4'($urandom),
                           1'($urandom), kind == 0,
                           ($urandom_range(0, 7) == 0) ? BT - 1 : $urandom_range(0, 5));
            end
        end

        // Back-to-back packets, then silence past the link timeout
        p0 = pulses;
        sendPacket(12'h111, 12'h222, 1'b0, 2'd1, 4'd1, 1'b0, 1'b0, 0);
        sendPacket(12'h333, 12'h444, 1'b1, 2'd2, 4'd2, 1'b0, 1'b0, 0);
        checkOutput("b2b_pulses", 32'(pulses - p0), 32'd2);
        checkOutput("b2b_x", 32'(player_2_x), 32'h333);
        idle(LT + 5);
        checkOutput("link_lost", 32'(link_alive), 32'd0);

        for (int i = 0; i < 260; i++)
            sendPacket(12'($urandom), 12'($urandom), 1'b0, 2'd1, 4'd4, 1'b0, 1'b1, 0);
        checkOutput("err_saturated", 32'(pkt_err_cnt), 32'd255);

        sendByte(8'hA5, 0);
        sendByte(8'h1F, 0);
        sendByte(8'h41, 0);
        doReset();
        sendPacket(12'h0F0, 12'h00F, 1'b0, 2'd2, 4'd7, 1'b0, 1'b0, 1);
        checkOutput("post_reset_y", 32'(player_2_y), 32'h00F);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
